data_ram_responder: RTL and testbench

//  Memory-side responder for the cpu RAM interface (ram_EN/ram_RW/address/data).

---
 rtl/dianthus_pkg.sv | 17 +
 rtl/io_sync_edge.sv | 31 +++
 rtl/data_ram_responder.sv | 128 ++++++++++++
 tb/tb_data_ram_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dianthus_pkg.sv
// rtl/dianthus_pkg.sv - shared types and I/O map constants for the data RAM responder
package dianthus_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_e;

  localparam logic [1:0] IO_OUT  = 2'd0;
  localparam logic [1:0] IO_IN   = 2'd1;
  localparam logic [1:0] IO_EDGE = 2'd2;
  localparam logic [1:0] IO_ID   = 2'd3;

  localparam int DATA_W_DEF = 4;

endpackage

// File: rtl/io_sync_edge.sv
// rtl/io_sync_edge.sv - two-flop synchronizer with rising-edge pulse on the synced value
module io_sync_edge #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] async_i,
  output logic [DATA_W-1:0] sync_o,
  output logic [DATA_W-1:0] rise_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - cpu RAM-bus responder: zero-filled data RAM plus four I/O regs
module data_ram_responder
  import dianthus_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE = 8'hFC,
  parameter logic [DATA_W-1:0] DEV_ID  = 4'hA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_EN,
  input  logic              ram_RW,
  input  logic [ADDR_W-1:0] ram_address_bus,
  input  logic [DATA_W-1:0] ram_data_bus_wr,
  output logic [DATA_W-1:0] ram_data_bus_rd,
  output logic              ram_busy,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  state_e            state_q;
  logic [ADDR_W-1:0] counter_q;
  logic              busy_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] io_out_q;
  logic [DATA_W-1:0] flags_q;
  logic [DATA_W-1:0] flags_d;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] io_sync;
  logic [DATA_W-1:0] io_rise;

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] io_offset;
  logic [1:0]        io_sel;
  logic              is_io;
  logic              active;
  logic              wr_req;
  logic              rd_req;
  logic              clr_edge;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  io_sync_edge #(.DATA_W(DATA_W)) u_io_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (io_in),
    .sync_o  (io_sync),
    .rise_o  (io_rise)
  );

  // Offset subtraction keeps the I/O window correct for any IO_BASE, aligned or not.
  assign io_offset = ram_address_bus - IO_BASE;
  assign is_io     = (io_offset < ADDR_W'(4));
  assign io_sel    = io_offset[1:0];

  assign active   = ram_EN && (state_q != ST_INIT);
  assign wr_req   = active && ram_RW;
  assign rd_req   = active && !ram_RW;
  assign clr_edge = rd_req && is_io && (io_sel == IO_EDGE);

  // A rising edge arriving with the clearing read survives it.
  assign flags_d = (flags_q & ~{DATA_W{clr_edge}}) | io_rise;

  always_comb begin
    io_rdata = DEV_ID;
    case (io_sel)
      IO_OUT:  io_rdata = io_out_q;
      IO_IN:   io_rdata = io_sync;
      IO_EDGE: io_rdata = flags_q;
      default: io_rdata = DEV_ID;
    endcase
  end

  assign rd_d = is_io ? io_rdata : mem_q[ram_address_bus];

  assign mem_we    = (state_q == ST_INIT) || (wr_req && !is_io);
  assign mem_waddr = (state_q == ST_INIT) ? counter_q : ram_address_bus;
  assign mem_wdata = (state_q == ST_INIT) ? '0 : ram_data_bus_wr;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      counter_q <= '0;
      busy_q    <= 1'b1;
      rd_q      <= '0;
      io_out_q  <= '0;
      flags_q   <= '0;
    end else begin
      flags_q <= flags_d;
      case (state_q)
        ST_INIT: begin
          counter_q <= counter_q + 1'b1;
          if (counter_q == '1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE, ST_READ: begin
          if (rd_req) begin
            rd_q    <= rd_d;
            state_q <= ST_READ;
          end else begin
            state_q <= ST_IDLE;
          end
          if (wr_req && is_io && (io_sel == IO_OUT)) begin
            io_out_q <= ram_data_bus_wr;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign ram_data_bus_rd = rd_q;
  assign ram_busy        = busy_q;
  assign io_out          = io_out_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - directed self-checking bench for data_ram_responder
module tb_data_ram_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ram_EN = 1'b0;
  logic       ram_RW = 1'b0;
  logic [7:0] ram_address_bus = 8'h00;
  logic [3:0] ram_data_bus_wr = 4'h0;
  logic [3:0] ram_data_bus_rd;
  logic       ram_busy;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_ram_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_EN          (ram_EN),
    .ram_RW          (ram_RW),
    .ram_address_bus (ram_address_bus),
    .ram_data_bus_wr (ram_data_bus_wr),
    .ram_data_bus_rd (ram_data_bus_rd),
    .ram_busy        (ram_busy),
    .io_in           (io_in),
    .io_out          (io_out)
  );

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [7:0] a, input logic [3:0] d);
    ram_EN = 1'b1; ram_RW = 1'b1; ram_address_bus = a; ram_data_bus_wr = d;
    @(negedge clk);
    ram_EN = 1'b0; ram_RW = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [3:0] d);
    ram_EN = 1'b1; ram_RW = 1'b0; ram_address_bus = a;
    @(negedge clk);
    ram_EN = 1'b0;
    d = ram_data_bus_rd;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (ram_busy === 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] d;
    int cyc;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (ram_data_bus_rd !== 4'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", ram_data_bus_rd); end
    total++; if (io_out !== 4'h0) begin bad++; $display("FAIL reset_io_out got=%h exp=0", io_out); end
    total++; if (ram_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", ram_busy); end
    rst_n = 1'b1;
    wait_init(cyc);
    total++; if (cyc != 256) begin bad++; $display("FAIL init_len got=%0d exp=256", cyc); end
    do_read(8'h10, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL read_after_init got=%h exp=0", d); end
  endtask

  task automatic test_ram();
    logic [3:0] d;
    do_write(8'h20, 4'h7);
    do_read(8'h20, d);
    total++; if (d !== 4'h7) begin bad++; $display("FAIL ram_rw got=%h exp=7", d); end
    ram_RW = 1'b1; ram_address_bus = 8'h20; ram_data_bus_wr = 4'hF;
    @(negedge clk);
    ram_RW = 1'b0;
    total++; if (ram_data_bus_rd !== 4'h7) begin bad++; $display("FAIL rd_hold got=%h exp=7", ram_data_bus_rd); end
    do_read(8'h20, d);
    total++; if (d !== 4'h7) begin bad++; $display("FAIL en_low_no_write got=%h exp=7", d); end
    ram_EN = 1'b1; ram_RW = 1'b0; ram_address_bus = 8'h20;
    @(negedge clk);
    total++; if (ram_data_bus_rd !== 4'h7) begin bad++; $display("FAIL b2b_first got=%h exp=7", ram_data_bus_rd); end
    ram_address_bus = 8'h21;
    @(negedge clk);
    ram_EN = 1'b0;
    total++; if (ram_data_bus_rd !== 4'h0) begin bad++; $display("FAIL b2b_second got=%h exp=0", ram_data_bus_rd); end
  endtask

  task automatic test_io_regs();
    logic [3:0] d;
    do_write(8'hFC, 4'h5);
    total++; if (io_out !== 4'h5) begin bad++; $display("FAIL io_out_write got=%h exp=5", io_out); end
    do_write(8'hFD, 4'hF);
    do_write(8'hFF, 4'hF);
    do_read(8'hFF, d);
    total++; if (d !== 4'hA) begin bad++; $display("FAIL dev_id got=%h exp=a", d); end
    do_read(8'hFD, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL io_in_ro got=%h exp=0", d); end
    do_read(8'hFC, d);
    total++; if (d !== 4'h5) begin bad++; $display("FAIL io_out_readback got=%h exp=5", d); end
    total++; if (io_out !== 4'h5) begin bad++; $display("FAIL io_out_kept got=%h exp=5", io_out); end
  endtask

  task automatic test_io_in_edges();
    logic [3:0] d;
    io_in = 4'b0011;
    repeat (3) @(negedge clk);
    do_read(8'hFD, d);
    total++; if (d !== 4'h3) begin bad++; $display("FAIL io_in_sync got=%h exp=3", d); end
    do_read(8'hFE, d);
    total++; if (d !== 4'h3) begin bad++; $display("FAIL edge_flags got=%h exp=3", d); end
    do_read(8'hFE, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL edge_cleared got=%h exp=0", d); end
  endtask

  task automatic test_edge_set_wins();
    logic [3:0] d;
    io_in = 4'b0111;
    @(negedge clk);
    @(negedge clk);
    do_read(8'hFE, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL edge_coincident_read got=%h exp=0", d); end
    do_read(8'hFE, d);
    total++; if (d !== 4'h4) begin bad++; $display("FAIL edge_set_wins got=%h exp=4", d); end
    do_read(8'hFE, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL edge_recleared got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] d;
    int cyc;
    do_write(8'h30, 4'h9);
    do_read(8'h20, d);
    total++; if (d !== 4'h7) begin bad++; $display("FAIL pre_reset_read got=%h exp=7", d); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ram_data_bus_rd !== 4'h0) begin bad++; $display("FAIL async_rst_rd got=%h exp=0", ram_data_bus_rd); end
    total++; if (io_out !== 4'h0) begin bad++; $display("FAIL async_rst_io_out got=%h exp=0", io_out); end
    total++; if (ram_busy !== 1'b1) begin bad++; $display("FAIL async_rst_busy got=%b exp=1", ram_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(8'h30, 4'h9);
    do_write(8'hFC, 4'h6);
    do_read(8'h20, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL init_read_dropped got=%h exp=0", d); end
    total++; if (io_out !== 4'h0) begin bad++; $display("FAIL init_write_dropped got=%h exp=0", io_out); end
    repeat (50) @(negedge clk);
    total++; if (ram_busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy got=%b exp=1", ram_busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ram_busy !== 1'b1) begin bad++; $display("FAIL sweep_rst_busy got=%b exp=1", ram_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cyc);
    total++; if (cyc != 256) begin bad++; $display("FAIL sweep_restart_len got=%0d exp=256", cyc); end
    do_read(8'h30, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL zero_fill got=%h exp=0", d); end
    do_read(8'h20, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL zero_fill_20 got=%h exp=0", d); end
    do_read(8'hFC, d);
    total++; if (d !== 4'h0) begin bad++; $display("FAIL io_out_after_rst got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io_regs();
    test_io_in_edges();
    test_edge_set_wins();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
